// File: rtl/p2r8_booth_digit_decode.sv
// Radix-8 Booth digit decoder: rebuilds the unsigned operand from its digit groups,
// MSB group first, one group per cycle. Optional checker: define P2R8_DEC_CHECK_EN.
module p2r8_booth_digit_decode #(
  parameter int WIDTH     = 8,
  parameter int GROUP_CNT = (WIDTH >> 2) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [GROUP_CNT-1:0] s,
  input  logic [GROUP_CNT-1:0] d,
  input  logic [GROUP_CNT-1:0] t,
  input  logic [GROUP_CNT-1:0] q,
  input  logic [GROUP_CNT-1:0] n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     mx_dec,
  output logic                 dec_err
);

  localparam int ACC_W = WIDTH + 4;
  localparam int GRP_W = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [GRP_W-1:0]         grp;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [GROUP_CNT-1:0]     s_r, d_r, t_r, q_r, n_r;
  logic [3:0]               hot;
  logic [3:0]               mag;
  logic signed [5:0]        digit;

  // Digit of the group being folded in; magnitude is the weighted OR-sum of s/d/t/q,
  // forced to zero on a multi-hot group when the checker is built.
  always_comb begin
    hot      = {q_r[grp], t_r[grp], d_r[grp], s_r[grp]};
    mag      = (hot[0] ? 4'd1 : 4'd0) + (hot[1] ? 4'd2 : 4'd0)
             + (hot[2] ? 4'd3 : 4'd0) + (hot[3] ? 4'd4 : 4'd0);
`ifdef P2R8_DEC_CHECK_EN
    if ((hot & (hot - 4'd1)) != 4'd0)
      mag = 4'd0;
`endif
    digit    = n_r[grp] ? (6'sd0 - $signed({2'b00, mag})) : $signed({2'b00, mag});
    acc_next = (acc <<< 3) + {{(ACC_W-6){digit[5]}}, digit};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mx_dec    <= '0;
      acc       <= '0;
      grp       <= '0;
      s_r       <= '0;
      d_r       <= '0;
      t_r       <= '0;
      q_r       <= '0;
      n_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_r      <= s;
            d_r      <= d;
            t_r      <= t;
            q_r      <= q;
            n_r      <= n;
            acc      <= '0;
            grp      <= GRP_W'(GROUP_CNT - 1);
            in_ready <= 1'b0;
            state    <= DEC;
          end
        end
        DEC: begin
          acc <= acc_next;
          if (grp == '0) begin
            mx_dec    <= acc_next[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            grp <= grp - GRP_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef P2R8_DEC_CHECK_EN
  logic multi_sticky;
  logic range_bad;

  assign range_bad = (acc_next[ACC_W-1:WIDTH] != '0);

  // Multi-hot flag accumulates over the pass; the final verdict is registered with the result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      multi_sticky <= 1'b0;
      dec_err      <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      multi_sticky <= 1'b0;
      dec_err      <= 1'b0;
    end else if (state == DEC) begin
      multi_sticky <= multi_sticky | ((hot & (hot - 4'd1)) != 4'd0);
      if (grp == '0)
        dec_err <= multi_sticky | ((hot & (hot - 4'd1)) != 4'd0) | range_bad;
    end
  end
`else
  assign dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_p2r8_booth_digit_decode.sv
// Directed bench for p2r8_booth_digit_decode (WIDTH=8, three digit groups).
module tb_p2r8_booth_digit_decode;

  localparam int WIDTH     = 8;
  localparam int GROUP_CNT = (WIDTH >> 2) + 1;
`ifdef P2R8_DEC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 in_valid;
  logic                 in_ready;
  logic [GROUP_CNT-1:0] s, d, t, q, n;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     mx_dec;
  logic                 dec_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  p2r8_booth_digit_decode #(.WIDTH(WIDTH), .GROUP_CNT(GROUP_CNT)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .d(d), .t(t), .q(q), .n(n),
    .out_valid(out_valid), .out_ready(out_ready),
    .mx_dec(mx_dec), .dec_err(dec_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one encoded operand and hold it until the acceptance edge has passed.
  task automatic applyStimulus(input logic [2:0] vs, input logic [2:0] vd, input logic [2:0] vt,
                               input logic [2:0] vq, input logic [2:0] vn);
    logic accepted;
    accepted = 1'b0;
    s = vs; d = vd; t = vt; q = vq; n = vn;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = in_ready;
      step();
    end
    in_valid = 1'b0;
    s = '0; d = '0; t = '0; q = '0; n = '0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitResult();
    for (int i = 0; i < 20 && !out_valid; i++) step();
  endtask

  task automatic runVector(input string tag, input logic [2:0] vs, input logic [2:0] vd,
                           input logic [2:0] vt, input logic [2:0] vq, input logic [2:0] vn,
                           input logic [7:0] exp_mx, input logic exp_err);
    applyStimulus(vs, vd, vt, vq, vn);
    waitResult();
    checkOutput({tag, "_ov"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_mx"}, 32'(mx_dec), 32'(exp_mx));
    checkOutput({tag, "_err"}, 32'(dec_err), 32'(exp_err));
    step();
    checkOutput({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic saw_ov;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    s = '0; d = '0; t = '0; q = '0; n = '0;
    step();
    step();
    checkOutput("rst_inrdy", 32'(in_ready), 32'd1);
    checkOutput("rst_ov", 32'(out_valid), 32'd0);
    checkOutput("rst_mx", 32'(mx_dec), 32'd0);
    checkOutput("rst_err", 32'(dec_err), 32'd0);
    RST = 1'b0;
    step();

    // All-zero operand with cycle-exact latency around the acceptance edge.
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    checkOutput("zero_inrdy_dec", 32'(in_ready), 32'd0);
    checkOutput("zero_lat0", 32'(out_valid), 32'd0);
    step();
    checkOutput("zero_lat1", 32'(out_valid), 32'd0);
    step();
    checkOutput("zero_lat2", 32'(out_valid), 32'd0);
    step();
    checkOutput("zero_lat3", 32'(out_valid), 32'd1);
    checkOutput("zero_mx", 32'(mx_dec), 32'h00);
    checkOutput("zero_err", 32'(dec_err), 32'd0);
    step();
    checkOutput("zero_ovdrop", 32'(out_valid), 32'd0);
    checkOutput("zero_inrdy_back", 32'(in_ready), 32'd1);

    // 64 + 24 + 2
    runVector("v5a", 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 8'h5A, 1'b0);
    // 256 - 1
    runVector("vff", 3'b001, 3'b000, 3'b000, 3'b100, 3'b001, 8'hFF, 1'b0);
    // 3*64 + 8
    runVector("vc8", 3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 8'hC8, 1'b0);
    // 128 - 32 + 4
    runVector("v64", 3'b000, 3'b100, 3'b000, 3'b011, 3'b010, 8'h64, 1'b0);
    // Multi-hot low group: dropped to 0 with checker, OR-sum 1+2 without
    runVector("multi", 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, CHK ? 8'h00 : 8'h03, CHK);
    // -64 is out of range; low bits still reported
    runVector("neg", 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 8'hC0, CHK);

    // Consumer stalls: result must hold steady.
    out_ready = 1'b0;
    applyStimulus(3'b100, 3'b001, 3'b010, 3'b000, 3'b000);
    waitResult();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_ov", 32'(out_valid), 32'd1);
      checkOutput("hold_mx", 32'(mx_dec), 32'h5A);
      step();
    end
    out_ready = 1'b1;
    step();
    checkOutput("hold_release", 32'(out_valid), 32'd0);

    // Reset while decoding discards the operand.
    applyStimulus(3'b001, 3'b000, 3'b000, 3'b100, 3'b001);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checkOutput("abort_inrdy", 32'(in_ready), 32'd1);
    checkOutput("abort_ov", 32'(out_valid), 32'd0);
    checkOutput("abort_mx", 32'(mx_dec), 32'd0);
    saw_ov = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      saw_ov = saw_ov | out_valid;
    end
    checkOutput("abort_no_ov", 32'(saw_ov), 32'd0);

    // Reset coinciding with in_valid: the operand is not taken.
    s = 3'b100; in_valid = 1'b1; RST = 1'b1;
    step();
    RST = 1'b0; in_valid = 1'b0; s = '0;
    checkOutput("rstwin_inrdy", 32'(in_ready), 32'd1);
    step();
    checkOutput("rstwin_inrdy2", 32'(in_ready), 32'd1);
    checkOutput("rstwin_ov", 32'(out_valid), 32'd0);

    runVector("recover", 3'b000, 3'b100, 3'b000, 3'b011, 3'b010, 8'h64, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
